regfile_writeback: RTL and testbench

Write-side front end for the 32-bit CPU register file. It merges ALU results and returning load data onto the register file's single write port (WE0/REGNUM2/data_in), buffering load returns in a small FIFO while the ALU holds priority. It also keeps a per-register pending-load scoreboard that the issue stage reads to detect hazards. It sits between the execute/memory stages and the register file and owns every register-file write.

---
 rtl/regfile_wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/regfile_writeback.sv | 124 ++++++++++++
 tb/tb_regfile_writeback.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the register-file write-back front end.
package regfile_wb_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 1 << REG_AW;

    // FIFO and write-port payload; "regnum" because "reg" is a keyword
    typedef struct packed {
        logic [REG_AW-1:0] regnum;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries with combinational head view.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // The head must be visible in the cycle the arbiter decides to pop it
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU results and load returns onto the register-file write port and
// tracks pending loads. Define REGFILE_WB_BYPASS_EN to let loads skip an empty FIFO.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ALU_VALID,
    input  logic [REG_AW-1:0]         ALU_REG,
    input  logic [DATA_W-1:0]         ALU_DATA,
    input  logic                      LD_ISSUE,
    input  logic [REG_AW-1:0]         LD_REG,
    input  logic                      LD_VALID,
    input  logic [REG_AW-1:0]         LD_RET_REG,
    input  logic [DATA_W-1:0]         LD_DATA,
    output logic                      LD_READY,
    output logic                      WE0,
    output logic [REG_AW-1:0]         REGNUM2,
    output logic [DATA_W-1:0]         data_in,
    output logic [NREG-1:0]           BUSY,
    output logic [$clog2(LQ_DEPTH):0] LQ_COUNT,
    output logic                      ERR
);

    logic      alu_sel;
    logic      ld_accept;
    logic      bypass;
    logic      push;
    logic      pop;
    logic      ld_set;
    logic      ld_clr;
    logic      fifo_full;
    logic      fifo_empty;
    logic      err_hit;
    wb_entry_t head;
    wb_entry_t wr_sel;
    wb_src_e   src;

    logic            we_reg;
    wb_entry_t       port_reg;
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            err_reg;

    assign alu_sel   = ALU_VALID && (ALU_REG != '0);
    assign ld_accept = LD_VALID && LD_READY && (LD_RET_REG != '0);

`ifdef REGFILE_WB_BYPASS_EN
    assign bypass = ld_accept && fifo_empty && !alu_sel;
`else
    assign bypass = 1'b0;
`endif

    assign push = ld_accept && !bypass;

    always_comb begin
        src    = SRC_NONE;
        wr_sel = head;
        if (alu_sel) begin
            src    = SRC_ALU;
            wr_sel = '{regnum: ALU_REG, data: ALU_DATA};
        end else if (!fifo_empty) begin
            src    = SRC_LD;
            wr_sel = head;
        end else if (bypass) begin
            src    = SRC_LD;
            wr_sel = '{regnum: LD_RET_REG, data: LD_DATA};
        end
    end

    assign ld_clr = (src == SRC_LD);
    assign pop    = ld_clr && !fifo_empty;
    assign ld_set = LD_ISSUE && (LD_REG != '0);

    wb_fifo #(
        .DEPTH(LQ_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data ('{regnum: LD_RET_REG, data: LD_DATA}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (LQ_COUNT)
    );

    // Set beats clear when a new load reissues to the register being written back
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        assign busy_next[gi] = (ld_set && (LD_REG == REG_AW'(gi))) ||
                               (busy_reg[gi] && !(ld_clr && (wr_sel.regnum == REG_AW'(gi))));
    end

    assign err_hit = (ld_set && busy_reg[LD_REG]) ||
                     (LD_VALID && !LD_READY) ||
                     (alu_sel && busy_reg[ALU_REG]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_reg   <= 1'b0;
            port_reg <= '0;
            busy_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            we_reg   <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                port_reg <= wr_sel;
            end
            busy_reg <= busy_next;
            err_reg  <= err_reg || err_hit;
        end
    end

    assign LD_READY = !fifo_full;
    assign WE0      = we_reg;
    assign REGNUM2  = port_reg.regnum;
    assign data_in  = port_reg.data;
    assign BUSY     = busy_reg;
    assign ERR      = err_reg;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based model.
module tb_regfile_writeback;

    localparam int LQ_DEPTH = 4;

    logic        CLK;
    logic        RST;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_reg;
    logic        ld_valid;
    logic [4:0]  ld_ret_reg;
    logic [31:0] ld_data;
    logic        LD_READY;
    logic        WE0;
    logic [4:0]  REGNUM2;
    logic [31:0] data_in;
    logic [31:0] BUSY;
    logic [2:0]  LQ_COUNT;
    logic        ERR;

    regfile_writeback #(
        .LQ_DEPTH(LQ_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ALU_VALID  (alu_valid),
        .ALU_REG    (alu_reg),
        .ALU_DATA   (alu_data),
        .LD_ISSUE   (ld_issue),
        .LD_REG     (ld_reg),
        .LD_VALID   (ld_valid),
        .LD_RET_REG (ld_ret_reg),
        .LD_DATA    (ld_data),
        .LD_READY   (LD_READY),
        .WE0        (WE0),
        .REGNUM2    (REGNUM2),
        .data_in    (data_in),
        .BUSY       (BUSY),
        .LQ_COUNT   (LQ_COUNT),
        .ERR        (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: pending returns as a queue of {reg, data}
    logic [36:0] mq[$];
    logic [31:0] m_busy;
    logic        m_err;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        ld_issue = 0; ld_reg = 0;
        ld_valid = 0; ld_ret_reg = 0; ld_data = 0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_busy = 0; m_err = 0; m_we = 0; m_reg = 0; m_data = 0;
    endtask

    task automatic check_all();
        check_val("we0", 64'(WE0), 64'(m_we));
        check_val("regnum2", 64'(REGNUM2), 64'(m_reg));
        check_val("data_in", 64'(data_in), 64'(m_data));
        check_val("busy", 64'(BUSY), 64'(m_busy));
        check_val("lq_count", 64'(LQ_COUNT), 64'(mq.size()));
        check_val("ld_ready", 64'(LD_READY), 64'(mq.size() < LQ_DEPTH));
        check_val("err", 64'(ERR), 64'(m_err));
    endtask

    // Apply the current inputs to the model, clock once, compare everything
    task automatic step();
        logic        ready;
        logic        alu_ok;
        logic        taken;
        logic [36:0] e;
        ready  = (mq.size() < LQ_DEPTH);
        alu_ok = alu_valid && (alu_reg != 0);
        taken  = 0;
        if (ld_issue && ld_reg != 0 && m_busy[ld_reg]) m_err = 1;
        if (ld_valid && !ready) m_err = 1;
        if (alu_ok && m_busy[alu_reg]) m_err = 1;
        m_we = 0;
        if (alu_ok) begin
            m_we = 1; m_reg = alu_reg; m_data = alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1; m_reg = e[36:32]; m_data = e[31:0];
            m_busy[m_reg] = 0;
        end
`ifdef REGFILE_WB_BYPASS_EN
        else if (ld_valid && ld_ret_reg != 0) begin
            m_we = 1; m_reg = ld_ret_reg; m_data = ld_data;
            m_busy[m_reg] = 0;
            taken = 1;
        end
`endif
        if (ld_valid && ready && ld_ret_reg != 0 && !taken) mq.push_back({ld_ret_reg, ld_data});
        if (ld_issue && ld_reg != 0) m_busy[ld_reg] = 1;
        @(posedge CLK);
        #1;
        check_all();
        if (WE0) $display("write r%0d = %08h (lq=%0d busy=%08h err=%0b)", REGNUM2, data_in, LQ_COUNT, BUSY, ERR);
    endtask

    // Assert reset between edges and check the outputs clear without a clock
    task automatic mid_reset();
        idle_inputs();
        #2;
        RST = 1;
        #1;
        check_val("rst_we0", 64'(WE0), 64'd0);
        check_val("rst_busy", 64'(BUSY), 64'd0);
        check_val("rst_lq_count", 64'(LQ_COUNT), 64'd0);
        check_val("rst_ld_ready", 64'(LD_READY), 64'd1);
        check_val("rst_err", 64'(ERR), 64'd0);
        model_clear();
        @(posedge CLK);
        @(negedge CLK);
        RST = 0;
    endtask

    initial begin
        idle_inputs();
        model_clear();
        RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        check_val("init_regnum2", 64'(REGNUM2), 64'd0);
        @(negedge CLK);
        RST = 0;

        // ALU write, one-cycle latency, single-cycle pulse
        alu_valid = 1; alu_reg = 5; alu_data = 32'h1234_5678;
        step();
        check_val("alu_we", 64'(WE0), 64'd1);
        check_val("alu_reg", 64'(REGNUM2), 64'd5);
        check_val("alu_data", 64'(data_in), 64'h1234_5678);
        idle_inputs();
        step();
        check_val("alu_we_drop", 64'(WE0), 64'd0);

        // Load to r7 through scoreboard and FIFO (or bypass)
        ld_issue = 1; ld_reg = 7;
        step();
        check_val("busy7_set", 64'(BUSY[7]), 64'd1);
        idle_inputs();
        ld_valid = 1; ld_ret_reg = 7; ld_data = 32'hDEAD_0001;
        step();
        idle_inputs();
`ifdef REGFILE_WB_BYPASS_EN
        check_val("ld7_we", 64'(WE0), 64'd1);
        check_val("ld7_reg", 64'(REGNUM2), 64'd7);
        check_val("busy7_clr", 64'(BUSY[7]), 64'd0);
        step();
`else
        check_val("ld7_we_early", 64'(WE0), 64'd0);
        step();
        check_val("ld7_we", 64'(WE0), 64'd1);
        check_val("ld7_reg", 64'(REGNUM2), 64'd7);
        check_val("ld7_data", 64'(data_in), 64'hDEAD_0001);
        check_val("busy7_clr", 64'(BUSY[7]), 64'd0);
`endif

        // Register 0 targets are dropped
        alu_valid = 1; alu_reg = 0; alu_data = 32'hFFFF_FFFF;
        ld_valid = 1; ld_ret_reg = 0; ld_data = 32'hAAAA_5555;
        step();
        check_val("r0_we", 64'(WE0), 64'd0);
        check_val("r0_lq", 64'(LQ_COUNT), 64'd0);
        idle_inputs();
        step();
        check_val("r0_we2", 64'(WE0), 64'd0);

        // Double issue to r3, then reissue r4 on its write-back edge
        ld_issue = 1; ld_reg = 3;
        step();
        step();
        check_val("dbl_issue_err", 64'(ERR), 64'd1);
        ld_reg = 4;
        step();
        idle_inputs();
        ld_valid = 1; ld_ret_reg = 4; ld_data = 32'h0000_0444;
`ifdef REGFILE_WB_BYPASS_EN
        ld_issue = 1; ld_reg = 4;
        step();
`else
        step();
        idle_inputs();
        ld_issue = 1; ld_reg = 4;
        step();
`endif
        check_val("r4_wb_we", 64'(WE0), 64'd1);
        check_val("r4_wb_reg", 64'(REGNUM2), 64'd4);
        check_val("busy4_kept", 64'(BUSY[4]), 64'd1);
        idle_inputs();
        step();
        mid_reset();

        // ALU held for 6 cycles while 5 returns arrive; the fifth overflows
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_reg = 1; alu_data = 32'h100 + i;
            ld_valid = (i < 5); ld_ret_reg = 5'(8 + i); ld_data = 32'hC0DE_0000 + i;
            step();
            if (i == 3) begin
                check_val("full_count", 64'(LQ_COUNT), 64'd4);
                check_val("full_ready", 64'(LD_READY), 64'd0);
            end
            if (i == 4) check_val("overflow_err", 64'(ERR), 64'd1);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("drain_we", 64'(WE0), 64'd1);
            check_val("drain_reg", 64'(REGNUM2), 64'(8 + i));
            check_val("drain_data", 64'(data_in), 64'(32'hC0DE_0000 + i));
        end
        step();
        check_val("drain_done", 64'(WE0), 64'd0);
        mid_reset();

        // Reset while three returns are queued and a write is in flight
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_reg = 2; alu_data = 32'h2000 + i;
            ld_issue = 1; ld_reg = 5'(13 + i);
            ld_valid = 1; ld_ret_reg = 5'(13 + i); ld_data = 32'hB000_0000 + i;
            step();
        end
        check_val("pre_rst_count", 64'(LQ_COUNT), 64'd3);
        mid_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("post_rst_we", 64'(WE0), 64'd0);
        end

        // Randomized traffic with periodic mid-cycle resets
        for (int c = 0; c < 600; c++) begin
            alu_valid  = ($urandom_range(0, 2) == 0);
            alu_reg    = 5'($urandom_range(0, 7));
            alu_data   = $urandom;
            ld_issue   = ($urandom_range(0, 2) == 0);
            ld_reg     = 5'($urandom_range(0, 7));
            ld_valid   = ($urandom_range(0, 1) == 0);
            ld_ret_reg = 5'($urandom_range(0, 7));
            ld_data    = $urandom;
            step();
            if (c % 150 == 149) mid_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
